// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared definitions for the divider issue/retire controller.
//   - Divider op codes and their width.
//   - RV32M funct3 -> divider op mapping.
//   - Special-case operand/result constants.
//   - Controller FSM state type.
package div_ctrl_pkg;

  localparam int DIV_OP_WIDTH = 2;

  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'd2;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'd3;

  // Most negative signed value and all-ones pattern used by the RISC-V
  // divide-by-zero and signed-overflow rules.
  localparam logic [31:0] DIV_INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // funct3 100/101/110/111 -> DIV/DIVU/REM/REMU.
  function automatic logic [DIV_OP_WIDTH-1:0] funct3_to_div_op(input logic [2:0] funct3);
    logic [DIV_OP_WIDTH-1:0] op;
    case (funct3[1:0])
      2'b00:   op = DIV_OP_DIV;
      2'b01:   op = DIV_OP_DIVU;
      2'b10:   op = DIV_OP_REM;
      default: op = DIV_OP_REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/div_special_case.sv
// div_special_case: combinational detector for the RISC-V division corner
// cases that need no iterative divider.
//   funct3 in  3   RV32M funct3 (bit 2 must be set for a divide op)
//   rs1    in  32  dividend
//   rs2    in  32  divisor
//   hit    out 1   operands form a divide-by-zero or signed-overflow case
//   rslt   out 32  architectural result for that case
module div_special_case
  import div_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        hit,
  output logic [31:0] rslt
);

  logic is_signed;
  logic is_rem;
  logic div_zero;
  logic overflow;

  assign is_signed = !funct3[0];
  assign is_rem    = funct3[1];
  assign div_zero  = (rs2 == 32'd0);
  assign overflow  = is_signed && (rs1 == DIV_INT_MIN) && (rs2 == DIV_ALL_ONES);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    hit  = 1'b0;
    rslt = '0;
    if (funct3[2]) begin
      // Divide-by-zero takes priority over overflow.
      if (div_zero) begin
        hit  = 1'b1;
        rslt = is_rem ? rs1 : DIV_ALL_ONES;
      end else if (overflow) begin
        hit  = 1'b1;
        rslt = is_rem ? 32'd0 : DIV_INT_MIN;
      end
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: issue/retire controller between the execute stage and an
// iterative divider. Resolves corner cases and repeated ops locally,
// otherwise runs the divider valid/ready handshake.
//   clk, reset          clock, synchronous active-high reset
//   op_valid/op_funct3  core request and RV32M funct3
//   op_rs1/op_rs2       dividend / divisor
//   kill                flush of the current request
//   busy                controller not idle
//   rslt/rslt_valid     result and its one-cycle pulse
//   div_divident/div_divisor/div_op/div_valid  request to the divider
//   div_ready/div_rslt  divider completion pulse and result
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1,
  parameter bit CACHE_EN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_valid,
  input  logic [2:0]              op_funct3,
  input  logic [31:0]             op_rs1,
  input  logic [31:0]             op_rs2,
  input  logic                    kill,
  output logic                    busy,
  output logic [31:0]             rslt,
  output logic                    rslt_valid,
  output logic [31:0]             div_divident,
  output logic [31:0]             div_divisor,
  output logic [DIV_OP_WIDTH-1:0] div_op,
  output logic                    div_valid,
  input  logic                    div_ready,
  input  logic [31:0]             div_rslt
);

  state_t      state;
  logic [2:0]  req_funct3;

  logic        accept;
  logic        sc_hit;
  logic [31:0] sc_rslt;
  logic        bypass_hit;
  logic        cache_hit;
  logic        cache_wr;

  logic        cache_valid;
  logic [2:0]  cache_funct3;
  logic [31:0] cache_rs1;
  logic [31:0] cache_rs2;
  logic [31:0] cache_rslt;

  div_special_case u_special_case (
    .funct3 (op_funct3),
    .rs1    (op_rs1),
    .rs2    (op_rs2),
    .hit    (sc_hit),
    .rslt   (sc_rslt)
  );

  // funct3[2] == 0 is not a divide op and is silently dropped.
  assign accept     = op_valid && !busy && !kill && op_funct3[2];
  assign bypass_hit = BYPASS_EN && sc_hit;
  assign cache_hit  = CACHE_EN && cache_valid && (cache_funct3 == op_funct3) &&
                      (cache_rs1 == op_rs1) && (cache_rs2 == op_rs2);
  // Every divider completion refreshes the cache, even a killed one.
  assign cache_wr   = CACHE_EN && div_ready && (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      rslt         <= '0;
      rslt_valid   <= 1'b0;
      div_valid    <= 1'b0;
      div_divident <= '0;
      div_divisor  <= '0;
      div_op       <= '0;
      req_funct3   <= '0;
      cache_valid  <= 1'b0;
    end else begin
      rslt_valid <= 1'b0;
      if (cache_wr) cache_valid <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bypass_hit) begin
              rslt       <= sc_rslt;
              rslt_valid <= 1'b1;
            end else if (cache_hit) begin
              rslt       <= cache_rslt;
              rslt_valid <= 1'b1;
            end else begin
              div_divident <= op_rs1;
              div_divisor  <= op_rs2;
              div_op       <= funct3_to_div_op(op_funct3);
              req_funct3   <= op_funct3;
              div_valid    <= 1'b1;
              busy         <= 1'b1;
              state        <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (div_ready) begin
            // Dropping valid on the ready edge keeps the divider from seeing
            // a second request for the same operands.
            div_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
            if (!kill) begin
              rslt       <= div_rslt;
              rslt_valid <= 1'b1;
            end
          end else if (kill) begin
            // The divider cannot be aborted; keep valid up and let it finish.
            state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (div_ready) begin
            div_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          div_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: only the valid bit needs a reset; the key/result registers are
  // never observed while the entry is invalid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!reset && cache_wr) begin
      cache_funct3 <= req_funct3;
      cache_rs1    <= div_divident;
      cache_rs2    <= div_divisor;
      cache_rslt   <= div_rslt;
    end
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Issue/retire controller that sits between the execute stage and the iterative divider. It does the following:
- Decodes RV32M funct3 into the divider op code.
- Resolves the RISC-V special cases (divide-by-zero, signed overflow) without starting the divider.
- Serves repeated identical operations from a one-entry result cache.
- Otherwise drives the divider valid/ready handshake and returns a single-cycle result pulse to the core.
- Supports kill (pipeline flush) while a division is in flight.

Parameters:
- BYPASS_EN, 1, enables the zero-divisor and signed-overflow shortcut paths.
- CACHE_EN, 1, enables the one-entry {funct3, rs1, rs2} -> result cache.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  core requests a DIV/DIVU/REM/REMU
- op_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_rs1  in  32  dividend
- op_rs2  in  32  divisor
- kill  in  1  flush; abandon current request
- busy  out  1  controller cannot accept a new op (state != IDLE)
- rslt  out  32  result, valid while rslt_valid
- rslt_valid  out  1  one-cycle result pulse
- div_divident  out  32  registered operand to divider
- div_divisor  out  32  registered operand to divider
- div_op  out  DIV_OP_WIDTH  registered divider op code
- div_valid  out  1  request to divider, held until div_ready
- div_ready  in  1  divider completion pulse (one cycle)
- div_rslt  in  32  divider quotient or remainder

Behaviour:
- Reset values: busy=0, rslt=0, rslt_valid=0, div_valid=0, div_divident=0, div_divisor=0, div_op=0, cache entry invalid, state=IDLE.
- Accept: an op is accepted when op_valid && !busy && !kill. op_funct3[2]=0 is illegal; such an op is ignored (not accepted).
- States:
  - IDLE: on accept, check the shortcut paths in priority order:
    1. Divisor == 0 (BYPASS_EN): quotient 0xFFFFFFFF, remainder rs1.
    2. Signed overflow, rs1 == 0x80000000 && rs2 == 0xFFFFFFFF with DIV/REM (BYPASS_EN): quotient 0x80000000, remainder 0.
    3. Cache hit (CACHE_EN): entry valid and {funct3, rs1, rs2} matches.

    On a shortcut: register rslt and pulse rslt_valid in the next cycle (latency 1); stay in IDLE. Back-to-back shortcut ops every cycle are legal.

    Otherwise: latch the operands and mapped op into div_*, set div_valid=1, go to WAIT.
  - WAIT:
    - div_ready=1 and kill=0: rslt <= div_rslt, rslt_valid=1 the next cycle, update the cache (if enabled), div_valid <= 0, go to IDLE.
    - kill=1 and div_ready=0: go to DRAIN; div_valid stays high.
    - kill=1 and div_ready=1 in the same cycle: discard the result (no rslt_valid), still update the cache, go to IDLE.
  - DRAIN: wait for div_ready. Then div_valid <= 0, update the cache, no rslt_valid, go to IDLE. kill is ignored in this state.
- Divider handshake:
  - div_valid must deassert on the same edge at which div_ready is sampled high. It is never reasserted in the cycle immediately after div_ready.
  - The divider ignores valid while its ready is high, so an op accepted in the first IDLE cycle raises div_valid one cycle later, which is legal.
- Latency on the divider path: accept edge -> div_valid (+1) -> divider latency -> div_ready -> rslt_valid (+1).
- div_valid, once set, stays high until div_ready. Operands and op stay stable for the whole request.
- Cache:
  - Single entry, written only from divider results.
  - Key includes funct3, so DIV and REM on the same operands are distinct entries.
  - Invalidated only by reset.
- rslt holds its last value between pulses. rslt_valid is never high for two consecutive cycles on the divider path.
- Reset mid-operation: all state is cleared. The divider shares this reset (its active-low reset is driven from the inverse of reset at the top), so no stale div_ready can arrive.

Decomposition:
- DIV_OP_* codes and DIV_OP_WIDTH come from riscv_defines.vh. Add the funct3-to-DIV_OP mapping and the constants 0x80000000 / 0xFFFFFFFF as shared defines.
- One combinational sub-module, div_special_case: inputs funct3/rs1/rs2; outputs hit flag and result. It is reused by any future fast-path logic.
- FSM and cache stay in div_ctrl.

Test Plan:
- DIV 100/7, divider model 10 cycles -> div_valid 1 cycle after accept, div_op=DIV, rslt=14 with a single rslt_valid pulse, busy low afterwards.
- REM 100/7 immediately after, then REM 100/7 again -> first goes to the divider with rslt=2; second is a cache hit with rslt=2 one cycle after accept and no div_valid.
- DIVU 5/0 then REM 0x80000000/0xFFFFFFFF -> rslt=0xFFFFFFFF, then rslt=0; neither asserts div_valid; the two results pulse on consecutive cycles.
- DIV -20/3 with kill 3 cycles after accept -> state DRAIN, div_valid held until div_ready, no rslt_valid, busy until the divider finishes; a following DIV -20/3 hits the cache with rslt=0xFFFFFFFA.
- kill coincident with div_ready; op_valid held high during busy -> no rslt_valid, the op is accepted the cycle after busy drops, div_valid is low for at least one cycle between requests.
- reset asserted during WAIT -> all outputs at reset values the next cycle; cache miss on a repeat of the same op.
